// File: rtl/arith_pkg.sv
// Shared operation encodings and FSM state type for the sequential arithmetic unit.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/arith_step.sv
// One combinational iteration of the shared multiply (add-and-shift-right) or
// restoring divide (shift-left-compare-subtract) datapath on a 2*WIDTH accumulator.
module arith_step #(
    parameter int WIDTH = 16
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]   w_hi_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_sub;

    always_comb begin
        w_hi_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        // Shifted remainder needs one extra bit; the difference always fits in WIDTH.
        w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
        w_rem_sub = w_rem_sh[WIDTH-1:0] - i_operand;
        if (i_div) begin
            if (w_rem_sh >= {1'b0, i_operand})
                o_acc = {w_rem_sub, i_acc[WIDTH-2:0], 1'b1};
            else
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc = {w_hi_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_arithmetic_unit.sv
// Multi-cycle add/sub/mul/div unit with start/busy/done handshake.
// Optional macro SEQ_ARITH_REMAINDER_EN adds the registered 'rem' output.
module seq_arithmetic_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             over_under_flow
`ifdef SEQ_ARITH_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] rem
`endif
);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_is_div;
    logic               w_sub_ovf;
    logic               w_div0;
    logic               w_last;
    logic               w_finish;
    logic [WIDTH-1:0]   w_res;
    logic               w_flag;

    assign w_is_div = (r_op == OP_DIV);

    // Multiplier and dividend both start in the low half, so operand B drives both ops.
    arith_step #(.WIDTH(WIDTH)) u_step (
        .i_div     (w_is_div),
        .i_acc     (r_acc),
        .i_operand (r_opb),
        .o_acc     (w_step)
    );

    always_comb begin
        w_sum     = {1'b0, r_opa} + {1'b0, r_opb};
        w_diff    = r_opa - r_opb;
        w_sub_ovf = (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]) & (w_diff[WIDTH-1] ^ r_opa[WIDTH-1]);
        w_div0    = w_is_div && (r_opb == '0);
        w_last    = (r_cnt == CNT_W'(WIDTH - 1));
        w_res     = '0;
        w_flag    = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_flag = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res  = w_diff;
                w_flag = w_sub_ovf;
            end
            OP_MUL: begin
                w_res  = w_step[WIDTH-1:0];
                w_flag = |w_step[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_res  = w_div0 ? '0 : w_step[WIDTH-1:0];
                w_flag = w_div0;
            end
        endcase
        w_finish = (r_state == CALC) &&
                   ((r_op == OP_ADD) || (r_op == OP_SUB) || w_div0 || w_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_op            <= OP_ADD;
            r_opa           <= '0;
            r_opb           <= '0;
            r_acc           <= '0;
            r_cnt           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            result          <= '0;
            over_under_flow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op    <= sel;
                        r_opa   <= ina;
                        r_opb   <= inb;
                        r_acc   <= {{WIDTH{1'b0}}, ina};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (w_finish) begin
                        result          <= w_res;
                        over_under_flow <= w_flag;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        r_state         <= DONE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ARITH_REMAINDER_EN
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        w_rem = '0;
        if (w_is_div)
            w_rem = w_div0 ? r_opa : w_step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rem <= '0;
        else if (w_finish)
            rem <= w_rem;
    end
`endif

endmodule
